// File: rtl/tmds_word_align.sv
// TMDS word aligner: slips the deserializer until control-token bursts are seen, then supervises lock. TMDS_ALIGN_RELOCK_CNT_EN adds relock_cnt.
// Latency: pmerdy rises 2 edges after the Nth token appears on rawdata; no backpressure, one symbol accepted per pixelclk.
module tmds_word_align #(
  parameter int CTRL_CNT_TH   = 8,
  parameter int SEARCH_CYCLES = 1048576,
  parameter int SLIP_WAIT     = 16,
  parameter int LOCK_LOSS_TH  = 4
) (
  input  logic       pixelclk,
  input  logic       rst,
  input  logic [9:0] rawdata,
  output logic       bitslip,
  output logic [3:0] slip_cnt,
  output logic       pmerdy,
  output logic       align_err
`ifdef TMDS_ALIGN_RELOCK_CNT_EN
  ,
  output logic [7:0] relock_cnt
`endif
);

  localparam int RUN_W   = $clog2(CTRL_CNT_TH + 1);
  localparam int TIMER_W = (SEARCH_CYCLES > 2) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int WAIT_W  = (SLIP_WAIT > 2) ? $clog2(SLIP_WAIT) : 1;
  localparam int MISS_W  = (LOCK_LOSS_TH > 2) ? $clog2(LOCK_LOSS_TH) : 1;

  localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(CTRL_CNT_TH);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CTRL_CNT_TH - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEARCH_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOCK_LOSS_TH - 1);

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

  state_t              state;
  logic [9:0]          raw_q;
  logic [RUN_W-1:0]    run_cnt;
  logic [TIMER_W-1:0]  timer;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic                tok_hit;
  logic                burst;

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) raw_q <= '0;
    else     raw_q <= rawdata;
  end

  assign tok_hit = (raw_q == 10'b1101010100) || (raw_q == 10'b0010101011) ||
                   (raw_q == 10'b0101010100) || (raw_q == 10'b1010101011);

  // Firing only on the exact count makes a long blanking run produce a single burst.
  assign burst = tok_hit && (run_cnt == RUN_LAST);

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst)                            run_cnt <= '0;
    else if (state == WAIT || !tok_hit) run_cnt <= '0;
    else if (run_cnt != RUN_MAX)        run_cnt <= run_cnt + 1'b1;
  end

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      timer     <= '0;
      wait_cnt  <= '0;
      miss_cnt  <= '0;
      bitslip   <= 1'b0;
      slip_cnt  <= '0;
      pmerdy    <= 1'b0;
      align_err <= 1'b0;
`ifdef TMDS_ALIGN_RELOCK_CNT_EN
      relock_cnt <= '0;
`endif
    end else begin
      case (state)
        SEARCH: begin
          if (burst) begin
            state     <= LOCKED;
            pmerdy    <= 1'b1;
            align_err <= 1'b0;
            timer     <= '0;
            miss_cnt  <= '0;
          end else if (timer == TIMER_LAST) begin
            state   <= SLIP;
            bitslip <= 1'b1;
            timer   <= '0;
            if (slip_cnt == 4'd9) begin
              slip_cnt  <= '0;
              align_err <= 1'b1;
            end else begin
              slip_cnt <= slip_cnt + 4'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SLIP: begin
          bitslip  <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= SEARCH;
            timer <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (burst) begin
            timer    <= '0;
            miss_cnt <= '0;
          end else if (timer == TIMER_LAST) begin
            timer <= '0;
            // Search resumes at the current slip position; no slip on lock loss.
            if (miss_cnt == MISS_LAST) begin
              state    <= SEARCH;
              pmerdy   <= 1'b0;
              miss_cnt <= '0;
`ifdef TMDS_ALIGN_RELOCK_CNT_EN
              if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
`endif
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_word_align.sv
// Directed bench for tmds_word_align with short windows (TH=8, window=64, wait=4, loss=2).
module tb_tmds_word_align;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] DATA = 10'h1F0;

  logic       pixelclk = 1'b0;
  logic       rst;
  logic [9:0] rawdata;
  logic       bitslip;
  logic [3:0] slip_cnt;
  logic       pmerdy;
  logic       align_err;
`ifdef TMDS_ALIGN_RELOCK_CNT_EN
  logic [7:0] relock_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  tmds_word_align #(
    .CTRL_CNT_TH  (8),
    .SEARCH_CYCLES(64),
    .SLIP_WAIT    (4),
    .LOCK_LOSS_TH (2)
  ) dut (
    .pixelclk (pixelclk),
    .rst      (rst),
    .rawdata  (rawdata),
    .bitslip  (bitslip),
    .slip_cnt (slip_cnt),
    .pmerdy   (pmerdy),
    .align_err(align_err)
`ifdef TMDS_ALIGN_RELOCK_CNT_EN
    ,
    .relock_cnt(relock_cnt)
`endif
  );

  always #5 pixelclk = ~pixelclk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one symbol; on return the outputs reflect the edge that registered it.
  task automatic drive(input logic [9:0] d);
    rawdata = d;
    @(posedge pixelclk);
    @(negedge pixelclk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge pixelclk);
    @(negedge pixelclk);
    rst = 1'b0;
    cyc = 0;
  endtask

  function automatic logic [9:0] rnd_data();
    logic [9:0] v;
    v = 10'($urandom_range(0, 1023));
    if (v == TOK0 || v == TOK1 || v == TOK2 || v == 10'b1010101011) v = DATA;
    return v;
  endfunction

  function automatic logic [9:0] stream_word(input int k);
    return ((k % 40) < 12) ? TOK0 : DATA;
  endfunction

  logic [3:0]  acc;
  logic [19:0] pair;
  int          phase, k, npulse, t0, t1, t2, dbl;
  logic        prev;
  logic [3:0]  s9;
  logic        e9;

  initial begin
    rst = 1'b0;
    rawdata = '0;
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rawdata = rnd_data();
      @(posedge pixelclk);
      @(negedge pixelclk);
      chk("rst_bitslip", bitslip, 0);
      chk("rst_slip_cnt", slip_cnt, 0);
      chk("rst_pmerdy", pmerdy, 0);
      chk("rst_align_err", align_err, 0);
    end
    rst = 1'b0;
    cyc = 0;

    acc = '0;
    for (int i = 0; i < 63; i++) begin
      drive(rnd_data());
      acc = acc | {bitslip, pmerdy, align_err, |slip_cnt};
    end
    chk("quiet_63", acc, 0);
    drive(rnd_data());
    chk("first_slip_pulse", bitslip, 1);
    chk("first_slip_cnt", slip_cnt, 1);
    drive(rnd_data());
    chk("first_slip_single", bitslip, 0);

    // async reset while in WAIT
    drive(rnd_data());
    rst = 1'b1;
    #1;
    chk("wait_rst_slip_cnt", slip_cnt, 0);
    chk("wait_rst_bitslip", bitslip, 0);
    chk("wait_rst_pmerdy", pmerdy, 0);
    @(posedge pixelclk);
    @(negedge pixelclk);
    rst = 1'b0;
    cyc = 0;

    // async reset during the bitslip pulse
    for (int i = 0; i < 64; i++) drive(DATA);
    chk("pulse_before_rst", bitslip, 1);
    rst = 1'b1;
    #1;
    chk("pulse_rst_bitslip", bitslip, 0);
    chk("pulse_rst_slip_cnt", slip_cnt, 0);
    @(negedge pixelclk);
    rst = 1'b0;
    cyc = 0;

    // aligned lock, preceded by a short run that must not lock
    do_reset();
    acc = '0;
    for (int i = 0; i < 7; i++) begin drive(TOK1); acc[0] = acc[0] | bitslip; end
    drive(DATA);
    drive(DATA);
    chk("short_run_no_lock", pmerdy, 0);
    for (int i = 0; i < 8; i++) begin drive(TOK0); acc[0] = acc[0] | bitslip; end
    chk("lock_not_early", pmerdy, 0);
    drive(DATA);
    chk("lock_pmerdy", pmerdy, 1);
    chk("lock_slip_cnt", slip_cnt, 0);
    chk("lock_no_bitslip", acc[0], 0);

    // lock loss after two empty supervision windows
    acc = 4'b0001;
    for (int i = 0; i < 127; i++) begin
      drive(DATA);
      acc[0] = acc[0] & pmerdy;
      acc[1] = acc[1] | bitslip;
    end
    chk("lock_held", acc, 4'b0001);
    drive(DATA);
    chk("lock_drop_pmerdy", pmerdy, 0);
    chk("lock_drop_slip_cnt", slip_cnt, 0);
    chk("lock_drop_bitslip", bitslip, 0);
`ifdef TMDS_ALIGN_RELOCK_CNT_EN
    chk("relock_cnt", relock_cnt, 1);
`endif
    acc = '0;
    for (int i = 0; i < 63; i++) begin drive(DATA); acc[0] = acc[0] | bitslip; end
    chk("relock_search_quiet", acc, 0);
    drive(DATA);
    chk("relock_slip_pulse", bitslip, 1);
    chk("relock_slip_cnt", slip_cnt, 1);

    // serializer model 3 bits off; each bitslip advances the word phase
    do_reset();
    phase = 7; k = 0; npulse = 0; dbl = 0; prev = 1'b0;
    t0 = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 600 && !pmerdy; i++) begin
      pair = {stream_word(k + 1), stream_word(k)} >> phase;
      drive(pair[9:0]);
      k++;
      if (bitslip) begin
        if (prev) dbl = 1;
        if (npulse == 0) t0 = cyc;
        if (npulse == 1) t1 = cyc;
        if (npulse == 2) t2 = cyc;
        npulse++;
        phase = (phase + 1) % 10;
      end
      prev = bitslip;
    end
    chk("seq_locked", pmerdy, 1);
    chk("seq_pulses", npulse, 3);
    chk("seq_first_at", t0, 64);
    chk("seq_gap1", t1 - t0, 69);
    chk("seq_gap2", t2 - t1, 69);
    chk("seq_single_cycle", dbl, 0);
    chk("seq_slip_cnt", slip_cnt, 3);

    // full sweep without tokens, then lock clears align_err
    do_reset();
    npulse = 0; s9 = '0; e9 = 1'b1;
    for (int i = 0; i < 800 && npulse < 10; i++) begin
      drive(DATA);
      if (bitslip) begin
        npulse++;
        if (npulse == 9) begin s9 = slip_cnt; e9 = align_err; end
      end
    end
    chk("sweep_pulses", npulse, 10);
    chk("sweep_10th_at", cyc, 685);
    chk("sweep_9_slip_cnt", s9, 9);
    chk("sweep_9_align_err", e9, 0);
    chk("sweep_wrap_slip_cnt", slip_cnt, 0);
    chk("sweep_align_err", align_err, 1);
    for (int i = 0; i < 6; i++) drive(DATA);
    for (int i = 0; i < 8; i++) drive(TOK0);
    chk("sweep_err_sticky", align_err, 1);
    drive(DATA);
    chk("sweep_lock_pmerdy", pmerdy, 1);
    chk("sweep_lock_align_err", align_err, 0);

    // burst completes on the timer-expiry cycle: lock wins
    do_reset();
    for (int i = 0; i < 55; i++) drive(DATA);
    for (int i = 0; i < 8; i++) drive(TOK2);
    drive(DATA);
    chk("edge_lock_pmerdy", pmerdy, 1);
    chk("edge_lock_bitslip", bitslip, 0);
    drive(DATA);
    chk("edge_lock_no_slip", bitslip, 0);
    chk("edge_lock_slip_cnt", slip_cnt, 0);

    // one cycle later the expiry wins and the run is lost
    do_reset();
    for (int i = 0; i < 56; i++) drive(DATA);
    for (int i = 0; i < 8; i++) drive(TOK2);
    chk("late_burst_slip", bitslip, 1);
    chk("late_burst_pmerdy", pmerdy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
